// File: rtl/sm_divider_if.sv
// Handshake/data bundle for sm_divider: start with operands in, registered results and status out.
interface sm_divider_if #(
  parameter int WORD_LENGTH = 16
);
  logic                   start;
  logic [WORD_LENGTH-1:0] A;
  logic [WORD_LENGTH-1:0] B;
  logic [WORD_LENGTH-1:0] quotient;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   busy;
  logic                   done;
  logic                   div_zero;

  modport master (
    output start, A, B,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, A, B,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/sm_divider.sv
// Sign-magnitude restoring divider, one quotient bit per cycle (WORD_LENGTH >= 3).
// Define SM_DIV_ZERO_CHECK_EN to short-cut |B|=0 straight to DONE with div_zero set.
module sm_divider #(
  parameter int WORD_LENGTH = 16
) (
  input logic         clk,
  input logic         rst,
  sm_divider_if.slave bus
);
  localparam int M  = WORD_LENGTH - 1;
  localparam int CW = $clog2(WORD_LENGTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [M-1:0]           a_q, a_d;
  logic [M-1:0]           b_q, b_d;
  logic [M-1:0]           r_q, r_d;
  logic                   sa_q, sa_d;
  logic                   sb_q, sb_d;
  logic [WORD_LENGTH-1:0] quot_q, quot_d;
  logic [WORD_LENGTH-1:0] rem_q, rem_d;
  logic                   done_q, done_d;
  logic [WORD_LENGTH-1:0] diff;
  logic                   ge;
  logic [M-1:0]           rem_mag;
`ifdef SM_DIV_ZERO_CHECK_EN
  logic                   zb_q, zb_d;
  logic                   dz_q, dz_d;
`endif

  // Trial subtract of the shifted partial remainder; the result never exceeds
  // +/-2^M, so its MSB doubles as the borrow (restore) indicator.
  assign diff = {r_q, a_q[M-1]} - {1'b0, b_q};
  assign ge   = ~diff[WORD_LENGTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    rem_mag = r_q;
`ifdef SM_DIV_ZERO_CHECK_EN
    zb_d    = zb_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A[M-1:0];
          b_d     = bus.B[M-1:0];
          r_d     = '0;
          cnt_d   = '0;
          sa_d    = bus.A[WORD_LENGTH-1] & (|bus.A[M-1:0]);
          sb_d    = bus.B[WORD_LENGTH-1] & (|bus.B[M-1:0]);
          state_d = CALC;
`ifdef SM_DIV_ZERO_CHECK_EN
          zb_d = ~(|bus.B[M-1:0]);
          if (zb_d) state_d = DONE;
`endif
        end
      end
      CALC: begin
        r_d    = ge ? diff[M-1:0] : {r_q[M-2:0], a_q[M-1]};
        a_d    = a_q << 1;
        a_d[0] = ge;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        quot_d  = {(sa_q ^ sb_q) & (|a_q), a_q};
`ifdef SM_DIV_ZERO_CHECK_EN
        dz_d = zb_q;
        if (zb_q) begin
          quot_d  = {1'b0, {M{1'b1}}};
          rem_mag = a_q;
        end
`endif
        rem_d = {sa_q & (|rem_mag), rem_mag};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
`ifdef SM_DIV_ZERO_CHECK_EN
      zb_q    <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
`ifdef SM_DIV_ZERO_CHECK_EN
      zb_q    <= zb_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
`ifdef SM_DIV_ZERO_CHECK_EN
  assign bus.div_zero  = dz_q;
`else
  assign bus.div_zero  = 1'b0;
`endif
endmodule
